fft_stage_sequencer: RTL

Control block that sequences a radix-2 decimation-in-time FFT over `SAMPLES` points. It walks every stage in order and issues one butterfly operand pair per handshake: two sample addresses plus a twiddle index. Between stages it waits until all issued butterflies have written back. It sits between the top-level FFT start/done control and the shared butterfly/sample-memory datapath, and it generalises the static per-stage pairing pattern into a run-time, back-pressured schedule.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_stage_sequencer_if.sv | 36 +++
 rtl/fft_pair_addr.sv | 33 +++
 rtl/fft_stage_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - Shared state type and sizing helpers for the FFT stage sequencer
package fft_pkg;

    localparam int FFT_SAMPLES_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_seq_state_t;

    function automatic int fft_log2n(input int samples);
        return $clog2(samples);
    endfunction

    // Twiddle ROM holds SAMPLES/2 entries; pair index p shares this width.
    function automatic int fft_tw_width(input int samples);
        return (fft_log2n(samples) > 1) ? fft_log2n(samples) - 1 : 1;
    endfunction

    function automatic int fft_outstanding_width(input int samples);
        return $clog2(samples / 2 + 1);
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - Butterfly operand issue and writeback handshake bundle
interface fft_stage_sequencer_if
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES_DEFAULT
);

    localparam int LOG2N = fft_log2n(SAMPLES);
    localparam int TW_W  = fft_tw_width(SAMPLES);

    logic             bf_valid;
    logic             bf_ready;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [TW_W-1:0]  tw_index;
    logic             bf_ret;

    modport master (
        output bf_valid,
        output addr_a,
        output addr_b,
        output tw_index,
        input  bf_ready,
        input  bf_ret
    );

    modport slave (
        input  bf_valid,
        input  addr_a,
        input  addr_b,
        input  tw_index,
        output bf_ready,
        output bf_ret
    );

endinterface

// File: rtl/fft_pair_addr.sv
// rtl/fft_pair_addr.sv - Combinational (stage, pair) to butterfly address/twiddle mapping
module fft_pair_addr
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES_DEFAULT
) (
    input  logic [$clog2(SAMPLES)-1:0] stage,
    input  logic [$clog2(SAMPLES)-2:0] p,
    output logic [$clog2(SAMPLES)-1:0] addr_a,
    output logic [$clog2(SAMPLES)-1:0] addr_b,
    output logic [$clog2(SAMPLES)-2:0] tw_index
);

    localparam int LOG2N = fft_log2n(SAMPLES);
    localparam int TW_W  = fft_tw_width(SAMPLES);

    localparam logic [TW_W-1:0]  TW_ONE = TW_W'(1);
    localparam logic [LOG2N-1:0] A_ONE  = LOG2N'(1);
    localparam logic [LOG2N-1:0] TW_TOP = LOG2N'(LOG2N - 1);

    logic [TW_W-1:0] j;
    logic [TW_W-1:0] i;

    // On the last stage TW_ONE << stage wraps to zero, so the mask becomes all ones.
    always_comb begin
        j        = p & ((TW_ONE << stage) - TW_ONE);
        i        = p >> stage;
        addr_a   = ({1'b0, i} << (stage + A_ONE)) | {1'b0, j};
        addr_b   = addr_a + (A_ONE << stage);
        tw_index = j << (TW_TOP - stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - Radix-2 DIT FFT stage walker issuing back-pressured butterfly pairs
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(SAMPLES)-1:0] stage,
    fft_stage_sequencer_if.master      bf
);

    localparam int LOG2N = fft_log2n(SAMPLES);
    localparam int TW_W  = fft_tw_width(SAMPLES);
    localparam int OUT_W = fft_outstanding_width(SAMPLES);

    localparam logic [TW_W-1:0]  P_LAST = TW_W'(SAMPLES / 2 - 1);
    localparam logic [TW_W-1:0]  P_ONE  = TW_W'(1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] S_ONE  = LOG2N'(1);
    localparam logic [OUT_W-1:0] O_ONE  = OUT_W'(1);

    fft_seq_state_t   state_q;
    fft_seq_state_t   state_d;
    logic [TW_W-1:0]  p_q;
    logic [TW_W-1:0]  p_d;
    logic [LOG2N-1:0] stage_q;
    logic [LOG2N-1:0] stage_d;
    logic [OUT_W-1:0] outs_q;
    logic [OUT_W-1:0] outs_d;

    logic             hs;
    logic             ret_ok;
    logic             valid_d;
    logic             busy_d;
    logic             done_d;
    logic [LOG2N-1:0] pa_addr_a;
    logic [LOG2N-1:0] pa_addr_b;
    logic [TW_W-1:0]  pa_tw;

    assign hs     = bf.bf_valid & bf.bf_ready;
    // A writeback with nothing outstanding belongs to a discarded run.
    assign ret_ok = bf.bf_ret & (outs_q != '0);
    assign stage  = stage_q;

    // Addresses are computed for the next-cycle pair so they can be registered.
    fft_pair_addr #(
        .SAMPLES (SAMPLES)
    ) u_pair_addr (
        .stage    (stage_d),
        .p        (p_d),
        .addr_a   (pa_addr_a),
        .addr_b   (pa_addr_b),
        .tw_index (pa_tw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            stage_q     <= '0;
            outs_q      <= '0;
            bf.bf_valid <= 1'b0;
            bf.addr_a   <= '0;
            bf.addr_b   <= '0;
            bf.tw_index <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            stage_q     <= stage_d;
            outs_q      <= outs_d;
            bf.bf_valid <= valid_d;
            bf.addr_a   <= pa_addr_a;
            bf.addr_b   <= pa_addr_b;
            bf.tw_index <= pa_tw;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        stage_d = stage_q;
        outs_d  = outs_q;

        if (hs && !ret_ok) begin
            outs_d = outs_q + O_ONE;
        end else if (!hs && ret_ok) begin
            outs_d = outs_q - O_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    p_d     = '0;
                    stage_d = '0;
                end
            end
            ST_ISSUE: begin
                if (hs) begin
                    if (p_q == P_LAST) begin
                        p_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        p_d = p_q + P_ONE;
                    end
                end
            end
            // Uses the post-update count so a return in this cycle releases the stage.
            ST_DRAIN: begin
                if (outs_d == '0) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + S_ONE;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

endmodule
